// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types and constants for the intersection sequencer and its light decoders.
// Pure declarations: no logic, no latency, no backpressure.
package traffic_phase_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FLASH = 3'd4
    } state_e;

    localparam logic [1:0] CAR_RED       = 2'd0;
    localparam logic [1:0] CAR_YELLOW    = 2'd1;
    localparam logic [1:0] CAR_GREEN     = 2'd2;
    localparam logic [1:0] PED_DONT_WALK = 2'd0;
    localparam logic [1:0] PED_FLASH     = 2'd1;
    localparam logic [1:0] PED_WALK      = 2'd2;

    localparam int unsigned APP_N = 0;
    localparam int unsigned APP_S = 1;
    localparam int unsigned APP_E = 2;
    localparam int unsigned APP_W = 3;

    localparam logic MODE_NS = 1'b0;
    localparam logic MODE_EW = 1'b1;

    localparam int CYCLE_W = 7;

    // The count never passes through 0 while running: 0 means "no phase" to the decoders.
    function automatic logic [CYCLE_W-1:0] cycle_inc(input logic [CYCLE_W-1:0] c,
                                                     input int unsigned last);
        return (c == CYCLE_W'(last)) ? CYCLE_W'(1) : c + CYCLE_W'(1);
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Board-side inputs and decoder-side outputs of the phase scheduler.
// Plain signal bundle: no latency, no backpressure.
interface traffic_phase_scheduler_if;
    logic       i_enable;
    logic [3:0] i_ped_req;
    logic       i_emg_req;
    logic       i_emg_dir;
    logic       i_night;
    logic [6:0] o_cycle;
    logic       o_mode_ns;
    logic       o_mode_ew;
    logic       o_all_red;
    logic       o_flash;
    logic [3:0] o_ped_ack;
    logic [3:0] o_ped_pend;
    logic [2:0] o_state;

    modport master (
        output i_enable, i_ped_req, i_emg_req, i_emg_dir, i_night,
        input  o_cycle, o_mode_ns, o_mode_ew, o_all_red, o_flash,
               o_ped_ack, o_ped_pend, o_state
    );

    modport slave (
        input  i_enable, i_ped_req, i_emg_req, i_emg_dir, i_night,
        output o_cycle, o_mode_ns, o_mode_ew, o_all_red, o_flash,
               o_ped_ack, o_ped_pend, o_state
    );
endinterface

// File: rtl/traffic_phase_scheduler_ped_latch.sv
// Pending pedestrian calls {W,E,S,N}; ack pulses one clock after the serving edge.
// Latency 1 clk; no backpressure, a request seen on the serving edge is acked, not latched.
module traffic_phase_scheduler_ped_latch
    import traffic_phase_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_i,
    input  logic       serve_ns_i,
    input  logic       serve_ew_i,
    output logic [3:0] pend_o,
    output logic [3:0] ack_o
);

    logic [3:0] pend_q, pend_d, ack_q, ack_d, mask, calls;

    always_comb begin
        mask        = '0;
        mask[APP_N] = serve_ns_i;
        mask[APP_S] = serve_ns_i;
        mask[APP_E] = serve_ew_i;
        mask[APP_W] = serve_ew_i;
        calls       = pend_q | req_i;
        pend_d      = calls & ~mask;
        ack_d       = calls & mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ack_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ack_q  <= ack_d;
        end
    end

    assign pend_o = pend_q;
    assign ack_o  = ack_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Intersection sequencer: cycle count, emergency preemption, night flash, ped calls.
// All outputs registered (1 clk from inputs); no backpressure, inputs sampled every clock.
module traffic_phase_scheduler
    import traffic_phase_scheduler_pkg::*;
#(
    parameter int unsigned CYCLE_LEN  = 68,
    parameter int unsigned EW_START   = 35,
    parameter int unsigned CLEAR_LEN  = 2,
    parameter int unsigned FLASH_HALF = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    traffic_phase_scheduler_if.slave tps
);

    if (CYCLE_LEN > 127 || CYCLE_LEN < 1 || EW_START < 1 || EW_START > CYCLE_LEN ||
        CLEAR_LEN < 1 || FLASH_HALF < 1) begin : g_param_chk
        $error("traffic_phase_scheduler: illegal parameter set");
    end

    localparam int CLR_W = (CLEAR_LEN > 1) ? $clog2(CLEAR_LEN) : 1;
    localparam int FL_W  = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    state_e             state_q, state_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic               ret_hold_q, ret_hold_d;
    logic               dir_q, dir_d;
    logic [CLR_W-1:0]   clr_q, clr_d;
    logic [FL_W-1:0]    fl_q, fl_d;
    logic               flash_q, flash_d;
    logic               all_red_q, all_red_d;
    logic               presented, serve_ns, serve_ew;

    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        ret_hold_d = ret_hold_q;
        dir_d      = dir_q;
        clr_d      = clr_q;
        fl_d       = fl_q;
        flash_d    = flash_q;

        if (!tps.i_enable) begin
            state_d = ST_IDLE;
            cycle_d = '0;
            clr_d   = '0;
            fl_d    = '0;
            flash_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d    = ST_CLEAR;
                    ret_hold_d = 1'b0;
                    clr_d      = '0;
                end
                ST_CLEAR: begin
                    if (clr_q == CLR_W'(CLEAR_LEN - 1)) begin
                        clr_d   = '0;
                        state_d = ret_hold_q ? ST_HOLD : ST_RUN;
                        cycle_d = (ret_hold_q && dir_q) ? CYCLE_W'(EW_START) : CYCLE_W'(1);
                    end else begin
                        clr_d = clr_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tps.i_emg_req) begin
                        state_d    = ST_CLEAR;
                        ret_hold_d = 1'b1;
                        dir_d      = tps.i_emg_dir;
                        clr_d      = '0;
                        cycle_d    = '0;
                    end else if (cycle_q == CYCLE_W'(CYCLE_LEN) && tps.i_night) begin
                        state_d = ST_FLASH;
                        cycle_d = '0;
                        fl_d    = '0;
                        flash_d = 1'b0;
                    end else begin
                        cycle_d = cycle_inc(cycle_q, CYCLE_LEN);
                    end
                end
                ST_HOLD: begin
                    if (!tps.i_emg_req) begin
                        state_d = ST_RUN;
                        cycle_d = cycle_inc(cycle_q, CYCLE_LEN);
                    end
                end
                ST_FLASH: begin
                    if (tps.i_emg_req || !tps.i_night) begin
                        state_d    = ST_CLEAR;
                        ret_hold_d = tps.i_emg_req;
                        dir_d      = tps.i_emg_req ? tps.i_emg_dir : dir_q;
                        clr_d      = '0;
                        fl_d       = '0;
                        flash_d    = 1'b0;
                    end else if (fl_q == FL_W'(FLASH_HALF - 1)) begin
                        fl_d    = '0;
                        flash_d = ~flash_q;
                    end else begin
                        fl_d = fl_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cycle_d = '0;
                end
            endcase
        end

        all_red_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
        // A value is served only on the clock it first appears, so a long HOLD acks once.
        presented = ((state_d == ST_RUN) || (state_d == ST_HOLD)) && (cycle_d != cycle_q);
        serve_ns  = presented && (cycle_d == CYCLE_W'(EW_START));
        serve_ew  = presented && (cycle_d == CYCLE_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cycle_q    <= '0;
            ret_hold_q <= 1'b0;
            dir_q      <= 1'b0;
            clr_q      <= '0;
            fl_q       <= '0;
            flash_q    <= 1'b0;
            all_red_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            ret_hold_q <= ret_hold_d;
            dir_q      <= dir_d;
            clr_q      <= clr_d;
            fl_q       <= fl_d;
            flash_q    <= flash_d;
            all_red_q  <= all_red_d;
        end
    end

    traffic_phase_scheduler_ped_latch u_ped (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (tps.i_ped_req),
        .serve_ns_i (serve_ns),
        .serve_ew_i (serve_ew),
        .pend_o     (tps.o_ped_pend),
        .ack_o      (tps.o_ped_ack)
    );

    assign tps.o_cycle   = cycle_q;
    assign tps.o_mode_ns = MODE_NS;
    assign tps.o_mode_ew = MODE_EW;
    assign tps.o_all_red = all_red_q;
    assign tps.o_flash   = flash_q;
    assign tps.o_state   = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed scenarios plus random traffic against a behavioural model of the scheduler.
module tb_traffic_phase_scheduler;

    localparam int CL  = 68;
    localparam int EWS = 35;
    localparam int CLR = 2;
    localparam int FH  = 8;
    localparam int S_IDLE = 0, S_CLEAR = 1, S_RUN = 2, S_HOLD = 3, S_FLASH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    traffic_phase_scheduler_if bus();

    traffic_phase_scheduler #(
        .CYCLE_LEN(CL), .EW_START(EWS), .CLEAR_LEN(CLR), .FLASH_HALF(FH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tps   (bus)
    );

    typedef struct packed {
        int       st;
        int       cyc;
        int       clear_left;
        bit       hold;
        bit       dir;
        int       fclk;
        bit [3:0] pend;
        bit [3:0] ack;
    } mdl_t;

    mdl_t cur, nxt;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_on  = 1'b0;
    bit   en, emg, dir, night;
    bit [3:0] ped;

    function automatic mdl_t reset_val();
        mdl_t m;
        m = '0;
        m.st = S_IDLE;
        return m;
    endfunction

    function automatic int exp_all_red(input mdl_t m);
        return (m.st == S_IDLE || m.st == S_CLEAR) ? 1 : 0;
    endfunction

    function automatic int exp_flash(input mdl_t m);
        return (m.st == S_FLASH) ? ((m.fclk / FH) % 2) : 0;
    endfunction

    // One clock of the intersection rules, from the visible state to the next visible state.
    function automatic mdl_t advance(input mdl_t m, input bit e, input bit [3:0] p,
                                     input bit g, input bit d, input bit nt);
        mdl_t n;
        n = m;
        n.ack = '0;
        if (!e) begin
            n.st = S_IDLE; n.cyc = 0; n.fclk = 0;
        end else begin
            case (m.st)
                S_IDLE:  begin n.st = S_CLEAR; n.clear_left = CLR; n.hold = 0; end
                S_CLEAR: begin
                    if (m.clear_left == 1) begin
                        n.st  = m.hold ? S_HOLD : S_RUN;
                        n.cyc = (m.hold && m.dir) ? EWS : 1;
                    end else n.clear_left = m.clear_left - 1;
                end
                S_RUN: begin
                    if (g) begin
                        n.st = S_CLEAR; n.clear_left = CLR; n.hold = 1; n.dir = d; n.cyc = 0;
                    end else if (m.cyc == CL && nt) begin
                        n.st = S_FLASH; n.cyc = 0; n.fclk = 0;
                    end else n.cyc = m.cyc % CL + 1;
                end
                S_HOLD: if (!g) begin n.st = S_RUN; n.cyc = m.cyc % CL + 1; end
                S_FLASH: begin
                    if (g || !nt) begin
                        n.st = S_CLEAR; n.clear_left = CLR; n.hold = g;
                        if (g) n.dir = d;
                    end else n.fclk = m.fclk + 1;
                end
                default: ;
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            bit hit, call;
            hit  = (n.st == S_RUN || n.st == S_HOLD) && (n.cyc != m.cyc) &&
                   (n.cyc == ((i < 2) ? EWS : 1));
            call = m.pend[i] | p[i];
            n.ack[i]  = call && hit;
            n.pend[i] = call && !hit;
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("o_cycle",    int'(bus.o_cycle),    cur.cyc);
            chk("o_state",    int'(bus.o_state),    cur.st);
            chk("o_all_red",  int'(bus.o_all_red),  exp_all_red(cur));
            chk("o_flash",    int'(bus.o_flash),    exp_flash(cur));
            chk("o_ped_pend", int'(bus.o_ped_pend), int'(cur.pend));
            chk("o_ped_ack",  int'(bus.o_ped_ack),  int'(cur.ack));
            chk("o_mode_ns",  int'(bus.o_mode_ns),  0);
            chk("o_mode_ew",  int'(bus.o_mode_ew),  1);
        end
    end

    task automatic step();
        bus.i_enable  = en;
        bus.i_ped_req = ped;
        bus.i_emg_req = emg;
        bus.i_emg_dir = dir;
        bus.i_night   = night;
        nxt = rst_n ? advance(cur, en, ped, emg, dir, night) : reset_val();
        @(posedge clk);
        cur = nxt;
        #2;
    endtask

    task automatic run_until(input int v);
        int k = 0;
        while (int'(bus.o_cycle) != v && k < 300) begin
            step();
            k++;
        end
        chk("reach_cycle", int'(bus.o_cycle), v);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 0; emg = 0; dir = 0; night = 0; ped = '0;
        bus.i_enable = 0; bus.i_ped_req = '0; bus.i_emg_req = 0;
        bus.i_emg_dir = 0; bus.i_night = 0;
        cur = reset_val();
        #1;
        chk_on = 1'b1;
        @(posedge clk); #2;
        chk("rst_state",   int'(bus.o_state),   0);
        chk("rst_cycle",   int'(bus.o_cycle),   0);
        chk("rst_all_red", int'(bus.o_all_red), 1);
        chk("rst_pend",    int'(bus.o_ped_pend), 0);
        rst_n = 1'b1;
        step(); step();
        chk("idle_state", int'(bus.o_state), S_IDLE);

        // Start-up clearance then the full count with wrap.
        en = 1;
        step();
        chk("clr1_state", int'(bus.o_state), S_CLEAR);
        chk("clr1_cycle", int'(bus.o_cycle), 0);
        step();
        chk("clr2_all_red", int'(bus.o_all_red), 1);
        step();
        chk("run_first", int'(bus.o_cycle), 1);
        chk("run_state", int'(bus.o_state), S_RUN);
        run_until(68);
        step();
        chk("wrap_to_1", int'(bus.o_cycle), 1);

        // North pedestrian call served at the NS ped-green start.
        run_until(5);
        ped = 4'b0001; step(); ped = '0;
        chk("ped_pend_set", int'(bus.o_ped_pend), 1);
        run_until(34);
        chk("ped_pend_hold", int'(bus.o_ped_pend), 1);
        step();
        chk("ped_ack", int'(bus.o_ped_ack), 1);
        chk("ped_pend_clr", int'(bus.o_ped_pend), 0);
        step();
        chk("ped_ack_pulse", int'(bus.o_ped_ack), 0);

        // EW preemption holding at EW_START; HOLD entry serves the South call.
        run_until(10);
        emg = 1; dir = 1; ped = 4'b0010; step(); ped = '0;
        chk("emg_clear", int'(bus.o_state), S_CLEAR);
        chk("emg_cycle0", int'(bus.o_cycle), 0);
        step(); step();
        chk("hold_state", int'(bus.o_state), S_HOLD);
        chk("hold_cycle", int'(bus.o_cycle), 35);
        chk("hold_ack", int'(bus.o_ped_ack), 2);
        dir = 0; step(); step();
        chk("hold_frozen", int'(bus.o_cycle), 35);
        emg = 0; step();
        chk("release_36", int'(bus.o_cycle), 36);
        step();
        chk("release_37", int'(bus.o_cycle), 37);

        // Night mode entered only at the end of the cycle.
        run_until(20);
        night = 1;
        run_until(68);
        chk("night_run", int'(bus.o_state), S_RUN);
        step();
        chk("flash_state", int'(bus.o_state), S_FLASH);
        chk("flash_cycle", int'(bus.o_cycle), 0);
        repeat (7) step();
        chk("flash_lo", int'(bus.o_flash), 0);
        step();
        chk("flash_hi", int'(bus.o_flash), 1);
        repeat (8) step();
        chk("flash_lo2", int'(bus.o_flash), 0);
        night = 0; step();
        chk("flash_exit", int'(bus.o_state), S_CLEAR);
        step(); step();
        chk("flash_resume", int'(bus.o_cycle), 1);

        // Emergency beats night at the wrap point.
        run_until(68);
        emg = 1; night = 1; dir = 0; step();
        chk("emg_over_night", int'(bus.o_state), S_CLEAR);
        step(); step();
        chk("hold_ns", int'(bus.o_state), S_HOLD);
        chk("hold_ns_cycle", int'(bus.o_cycle), 1);

        // Async reset mid-HOLD drops the pending call.
        ped = 4'b1000; step(); ped = '0;
        chk("hold_pend", int'(bus.o_ped_pend), 8);
        #1 rst_n = 1'b0;
        #1 cur = reset_val();
        chk("arst_state", int'(bus.o_state), 0);
        chk("arst_cycle", int'(bus.o_cycle), 0);
        chk("arst_pend",  int'(bus.o_ped_pend), 0);
        emg = 0; night = 0;
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        run_until(12);
        ped = 4'b0100; step(); ped = '0;
        chk("pend_e", int'(bus.o_ped_pend), 4);
        en = 0; step();
        chk("dis_state",   int'(bus.o_state), S_IDLE);
        chk("dis_cycle",   int'(bus.o_cycle), 0);
        chk("dis_all_red", int'(bus.o_all_red), 1);
        chk("dis_pend",    int'(bus.o_ped_pend), 4);
        en = 1; step(); step(); step();
        chk("reen_cycle", int'(bus.o_cycle), 1);

        // Random traffic, model-checked every clock.
        repeat (3000) begin
            if (en) begin
                if ($urandom_range(0, 299) == 0) en = 0;
            end else if ($urandom_range(0, 7) == 0) en = 1;
            ped = '0;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 29) == 0) ped[i] = 1'b1;
            if ($urandom_range(0, 59) == 0) emg = ~emg;
            dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 119) == 0) night = ~night;
            step();
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
